// File: rtl/iob_eth_rx_ring.sv
// Multi-slot Ethernet RX frame queue: buffers up to NSLOTS frames in one RAM,
// commits good frames in arrival order, drops bad/oversize/no-room frames.
module iob_eth_rx_ring #(
    parameter int BUF_ADDR_W = 11,
    parameter int NSLOTS     = 4,
    parameter int SLOT_W     = 2,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic                  in_err,
    input  logic [BUF_ADDR_W-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic [BUF_ADDR_W:0]   rd_nbytes,
    output logic                  rd_valid,
    // head-release strobe; the bare name "release" is a reserved word
    input  logic                  rd_release,
    output logic [SLOT_W:0]       count,
    output logic [DROP_W-1:0]     drop_cnt,
    input  logic                  clr_drop,
    input  logic                  int_en,
    output logic                  interrupt
);

    localparam int              DEPTH      = NSLOTS << BUF_ADDR_W;
    localparam logic [SLOT_W:0] FULL_COUNT = NSLOTS[SLOT_W:0];

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]       rd_slot_q, rd_slot_d;
    logic [BUF_ADDR_W:0]     wr_off_q, wr_off_d;
    logic [SLOT_W:0]         count_q, count_d;
    logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [BUF_ADDR_W:0]     len_q [NSLOTS];
    logic [BUF_ADDR_W:0]     len_d [NSLOTS];
    logic [7:0]              rd_data_q;
    logic [7:0]              mem [DEPTH];

    logic                    start;
    logic                    wr_en;
    logic [BUF_ADDR_W-1:0]   wr_byte_off;
    logic                    commit;
    logic [BUF_ADDR_W:0]     commit_len;
    logic                    drop_inc;
    logic                    rel_ok;

    always_comb begin
        state_d     = state_q;
        wr_off_d    = wr_off_q;
        start       = 1'b0;
        wr_en       = 1'b0;
        wr_byte_off = '0;
        commit      = 1'b0;
        commit_len  = '0;
        drop_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_sof) start = 1'b1;
            end
            S_RECV: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // abort the partial frame and restart the same slot
                        drop_inc = 1'b1;
                        start    = 1'b1;
                    end else if (wr_off_q[BUF_ADDR_W]) begin
                        drop_inc = 1'b1;
                        wr_off_d = '0;
                        state_d  = in_eof ? S_IDLE : S_DROP;
                    end else begin
                        wr_en       = 1'b1;
                        wr_byte_off = wr_off_q[BUF_ADDR_W-1:0];
                        wr_off_d    = wr_off_q + (BUF_ADDR_W+1)'(1);
                        if (in_eof) begin
                            state_d  = S_IDLE;
                            wr_off_d = '0;
                            if (in_err) begin
                                drop_inc = 1'b1;
                            end else begin
                                commit     = 1'b1;
                                commit_len = wr_off_q + (BUF_ADDR_W+1)'(1);
                            end
                        end
                    end
                end
            end
            S_DROP: begin
                if (in_valid) begin
                    if (in_sof)      start   = 1'b1;
                    else if (in_eof) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // frame start, shared by IDLE, RECV abort and DROP re-evaluation
        if (start) begin
            if (count_q == FULL_COUNT) begin
                drop_inc = 1'b1;
                wr_off_d = '0;
                state_d  = in_eof ? S_IDLE : S_DROP;
            end else begin
                wr_en       = 1'b1;
                wr_byte_off = '0;
                wr_off_d    = (BUF_ADDR_W+1)'(1);
                state_d     = S_RECV;
                if (in_eof) begin
                    state_d  = S_IDLE;
                    wr_off_d = '0;
                    if (in_err) begin
                        drop_inc = 1'b1;
                    end else begin
                        commit     = 1'b1;
                        commit_len = (BUF_ADDR_W+1)'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rel_ok    = rd_release && (count_q != '0);
        wr_slot_d = commit ? wr_slot_q + SLOT_W'(1) : wr_slot_q;
        rd_slot_d = rel_ok ? rd_slot_q + SLOT_W'(1) : rd_slot_q;
        count_d   = count_q;
        case ({commit, rel_ok})
            2'b10:   count_d = count_q + (SLOT_W+1)'(1);
            2'b01:   count_d = count_q - (SLOT_W+1)'(1);
            default: count_d = count_q;
        endcase

        drop_cnt_d = drop_cnt_q;
        if (clr_drop)
            drop_cnt_d = drop_inc ? DROP_W'(1) : '0;
        else if (drop_inc && (drop_cnt_q != {DROP_W{1'b1}}))
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            wr_off_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            wr_off_q   <= wr_off_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_len
        assign len_d[gi] = (commit && (wr_slot_q == SLOT_W'(gi))) ? commit_len : len_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) len_q[gi] <= '0;
            else        len_q[gi] <= len_d[gi];
        end
    end

    // frame storage is left uninitialised; only the length table is cleared
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_slot_q, wr_byte_off}] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[{rd_slot_q, rd_addr}];
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = (count_q != '0);
    assign rd_nbytes = rd_valid ? len_q[rd_slot_q] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;
    assign interrupt = int_en & rd_valid;

endmodule

// File: tb/tb_iob_eth_rx_ring.sv
// Directed bench for iob_eth_rx_ring: a frame/release vector table plus
// hand-written sequences for overflow, commit+release, saturation and reset.
module tb_iob_eth_rx_ring;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof, in_eof, in_err;
    logic [7:0]  in_data;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [11:0] rd_nbytes;
    logic        rd_valid;
    logic        rd_release;
    logic [2:0]  count;
    logic [15:0] drop_cnt;
    logic        clr_drop, int_en, interrupt;

    // narrow-counter instance sharing all inputs, used for saturation
    logic [7:0]  rd_data_s;
    logic [11:0] rd_nbytes_s;
    logic        rd_valid_s, interrupt_s;
    logic [2:0]  count_s;
    logic [3:0]  drop_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_eth_rx_ring dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_nbytes(rd_nbytes), .rd_valid(rd_valid),
        .rd_release(rd_release), .count(count), .drop_cnt(drop_cnt),
        .clr_drop(clr_drop), .int_en(int_en), .interrupt(interrupt)
    );

    iob_eth_rx_ring #(.DROP_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .rd_nbytes(rd_nbytes_s), .rd_valid(rd_valid_s),
        .rd_release(rd_release), .count(count_s), .drop_cnt(drop_cnt_s),
        .clr_drop(clr_drop), .int_en(int_en), .interrupt(interrupt_s)
    );

    typedef struct {
        int         len;
        logic       err;
        logic       rel;
        int         exp_count;
        int         exp_drop;
        int         exp_nb;
        logic       chk_b0;
        logic [7:0] exp_b0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
        in_data = 8'h00; rd_release = 1'b0; clr_drop = 1'b0;
    endtask

    // byte i of a frame carries seed+i; the trailing idle cycle makes a commit visible
    task automatic send_frame(input int len, input logic [7:0] seed, input logic err,
                              input logic rel_on_eof, input logic with_eof);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_sof     = (i == 0);
            in_eof     = with_eof && (i == len - 1);
            in_err     = err && (i == len - 1);
            rd_release = rel_on_eof && (i == len - 1);
            in_data    = 8'(int'(seed) + i);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic pulse_release();
        @(negedge clk); rd_release = 1'b1;
        @(negedge clk); rd_release = 1'b0;
    endtask

    task automatic read_byte(input int addr, output logic [7:0] data);
        @(negedge clk); rd_addr = 11'(addr);
        @(negedge clk); data = rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; idle_inputs();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic check_state(input string tag, input int c, input int d, input int nb);
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(d));
        check({tag, " rd_nbytes"}, 32'(rd_nbytes), 32'(nb));
    endtask

    task automatic check_byte(input string tag, input int addr, input logic [7:0] exp);
        logic [7:0] b;
        read_byte(addr, b);
        check(tag, 32'(b), 32'(exp));
    endtask

    initial begin
        logic [7:0] b;

        // len err rel  count drop nbytes  chk byte0
        vecs[0]  = '{64, 1'b0, 1'b0, 1, 0, 64, 1'b1, 8'h10};
        vecs[1]  = '{10, 1'b1, 1'b0, 1, 1, 64, 1'b1, 8'h10};
        vecs[2]  = '{ 1, 1'b0, 1'b0, 2, 1, 64, 1'b1, 8'h10};
        vecs[3]  = '{ 5, 1'b0, 1'b0, 3, 1, 64, 1'b1, 8'h10};
        vecs[4]  = '{ 7, 1'b0, 1'b0, 4, 1, 64, 1'b1, 8'h10};
        vecs[5]  = '{ 9, 1'b0, 1'b0, 4, 2, 64, 1'b1, 8'h10};
        vecs[6]  = '{ 0, 1'b0, 1'b1, 3, 2,  1, 1'b1, 8'h30};
        vecs[7]  = '{ 0, 1'b0, 1'b1, 2, 2,  5, 1'b1, 8'h40};
        vecs[8]  = '{ 0, 1'b0, 1'b1, 1, 2,  7, 1'b1, 8'h50};
        vecs[9]  = '{ 0, 1'b0, 1'b1, 0, 2,  0, 1'b0, 8'h00};
        vecs[10] = '{ 0, 1'b0, 1'b1, 0, 2,  0, 1'b0, 8'h00};
        vecs[11] = '{ 3, 1'b0, 1'b0, 1, 2,  3, 1'b1, 8'hC0};

        rst_n = 1'b0; int_en = 1'b1; rd_addr = '0; idle_inputs();
        #12;
        check("reset count", 32'(count), 0);
        check("reset drop_cnt", 32'(drop_cnt), 0);
        check("reset rd_nbytes", 32'(rd_nbytes), 0);
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset interrupt", 32'(interrupt), 0);
        check("reset rd_data", 32'(rd_data), 0);
        @(negedge clk); rst_n = 1'b1;

        // table: fill, overfill, error frame, drain, release-on-empty
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].len > 0) send_frame(vecs[v].len, 8'((v + 1) * 16), vecs[v].err, 1'b0, 1'b1);
            if (vecs[v].rel) pulse_release();
            check_state($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_drop, vecs[v].exp_nb);
            check($sformatf("vec%0d rd_valid", v), 32'(rd_valid), 32'(vecs[v].exp_count != 0));
            check($sformatf("vec%0d interrupt", v), 32'(interrupt), 32'(vecs[v].exp_count != 0));
            if (vecs[v].chk_b0) check_byte($sformatf("vec%0d byte0", v), 0, vecs[v].exp_b0);
        end

        // 64-byte frame read back in full, interrupt gated by int_en
        do_reset();
        int_en = 1'b0;
        send_frame(64, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state("f64", 1, 0, 64);
        check("f64 interrupt off", 32'(interrupt), 0);
        int_en = 1'b1;
        #1 check("f64 interrupt on", 32'(interrupt), 1);
        for (int a = 0; a < 64; a++) begin
            read_byte(a, b);
            check($sformatf("f64 byte%0d", a), 32'(b), 32'(a));
        end

        // oversize frame dropped, then normal and maximum-size frames
        do_reset();
        send_frame(2049, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state("ovf", 0, 1, 0);
        send_frame(60, 8'h20, 1'b0, 1'b0, 1'b1);
        check_state("after ovf", 1, 1, 60);
        check_byte("after ovf byte0", 0, 8'h20);
        check_byte("after ovf byte59", 59, 8'h5B);
        pulse_release();
        send_frame(2048, 8'h55, 1'b0, 1'b0, 1'b1);
        check_state("max", 1, 1, 2048);
        check_byte("max byte2047", 2047, 8'h54);

        // commit and release in the same cycle
        do_reset();
        send_frame(4, 8'h10, 1'b0, 1'b0, 1'b1);
        send_frame(6, 8'h20, 1'b0, 1'b0, 1'b1);
        check_state("cr pre", 2, 0, 4);
        send_frame(8, 8'h30, 1'b0, 1'b1, 1'b1);
        check_state("cr same", 2, 0, 6);
        check_byte("cr same byte0", 0, 8'h20);
        pulse_release();
        check_state("cr next", 1, 0, 8);
        check_byte("cr next byte0", 0, 8'h30);

        // sof inside a frame aborts it and restarts
        do_reset();
        send_frame(5, 8'h70, 1'b0, 1'b0, 1'b0);
        send_frame(3, 8'h80, 1'b0, 1'b0, 1'b1);
        check_state("abort", 1, 1, 3);
        check_byte("abort byte2", 2, 8'h82);

        // drop counter saturation (4-bit instance) and clear-with-drop
        do_reset();
        for (int k = 0; k < 17; k++) send_frame(1, 8'h00, 1'b1, 1'b0, 1'b1);
        check("sat main drop", 32'(drop_cnt), 17);
        check("sat small drop", 32'(drop_cnt_s), 15);
        check("sat count", 32'(count), 0);
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_err = 1'b1; clr_drop = 1'b1;
        @(negedge clk); idle_inputs();
        check("clr+drop main", 32'(drop_cnt), 1);
        check("clr+drop small", 32'(drop_cnt_s), 1);
        @(negedge clk); clr_drop = 1'b1;
        @(negedge clk); clr_drop = 1'b0;
        check("clr only", 32'(drop_cnt), 0);

        // asynchronous reset in the middle of a frame
        do_reset();
        send_frame(4, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h02, 1'b1, 1'b0, 1'b1);
        send_frame(4, 8'h03, 1'b0, 1'b0, 1'b1);
        check_state("pre rst", 2, 1, 4);
        send_frame(10, 8'h04, 1'b0, 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b1; in_data = 8'hEE;
        #2 rst_n = 1'b0;
        #1;
        check_state("mid rst", 0, 0, 0);
        check("mid rst rd_valid", 32'(rd_valid), 0);
        check("mid rst interrupt", 32'(interrupt), 0);
        check("mid rst rd_data", 32'(rd_data), 0);
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;
        send_frame(4, 8'h90, 1'b0, 1'b0, 1'b1);
        check_state("post rst", 1, 0, 4);
        check_byte("post rst byte0", 0, 8'h90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
